// File: rtl/mem_instr_sequencer.sv
// Control-step sequencer for ld/ldi/st: fetch, base+offset add, memory access.
// Ports: clock/clear, start, ir_opcode, mem_ready -> busy, done, error, step, strobes, alu_op.
module mem_instr_sequencer #(
  parameter int OPC_W = 5,
  parameter logic [OPC_W-1:0] LD_OP  = 'd0,
  parameter logic [OPC_W-1:0] LDI_OP = 'd1,
  parameter logic [OPC_W-1:0] ST_OP  = 'd2,
  parameter logic [OPC_W-1:0] ADD_OP = 'd3,
  parameter int TIMEOUT = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [OPC_W-1:0] ir_opcode,
  input  logic             mem_ready,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [3:0]       step,
  output logic             PCout,
  output logic             IncPC,
  output logic             PCin,
  output logic             ZlowIn,
  output logic             Zlowout,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Read,
  output logic             Write,
  output logic             Gra,
  output logic             Grb,
  output logic             Rout,
  output logic             Rin,
  output logic             BAout,
  output logic             Yin,
  output logic             Cout,
  output logic             mdr_bus_sel,
  output logic [OPC_W-1:0] alu_op
);

  localparam int CW =
    (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T1L  = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5I  = 4'd7,
    S_T5   = 4'd8,
    S_T6   = 4'd9,
    S_T6L  = 4'd10,
    S_T7   = 4'd11,
    S_T6S  = 4'd12,
    S_T7S  = 4'd13,
    S_DONE = 4'd14,
    S_ERR  = 4'd15
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            is_wait;
  logic            timed_out;
  logic            op_ld;
  logic            op_ldi;
  logic            op_st;

  assign op_ld  = (ir_opcode == LD_OP);
  assign op_ldi = (ir_opcode == LDI_OP);
  assign op_st  = (ir_opcode == ST_OP);

  assign is_wait = (state_q == S_T1) ||
                   (state_q == S_T6) ||
                   (state_q == S_T7S);

  // mem_ready on the final count edge takes priority over the timeout
  assign timed_out = (TIMEOUT != 0) &&
                     !mem_ready &&
                     (cnt_q == TO_LAST);

  // Held at zero outside wait states, so each wait entry starts from 0
  always_comb begin
    cnt_d = '0;
    if (is_wait && !mem_ready)
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    busy        = 1'b1;
    done        = 1'b0;
    error       = 1'b0;
    PCout       = 1'b0;
    IncPC       = 1'b0;
    PCin        = 1'b0;
    ZlowIn      = 1'b0;
    Zlowout     = 1'b0;
    MARin       = 1'b0;
    MDRin       = 1'b0;
    MDRout      = 1'b0;
    IRin        = 1'b0;
    Read        = 1'b0;
    Write       = 1'b0;
    Gra         = 1'b0;
    Grb         = 1'b0;
    Rout        = 1'b0;
    Rin         = 1'b0;
    BAout       = 1'b0;
    Yin         = 1'b0;
    Cout        = 1'b0;
    mdr_bus_sel = 1'b0;
    alu_op      = '0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start)
          state_d = S_T0;
      end
      S_T0: begin
        PCout   = 1'b1;
        IncPC   = 1'b1;
        ZlowIn  = 1'b1;
        MARin   = 1'b1;
        state_d = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        if (mem_ready)
          state_d = S_T1L;
        else if (timed_out)
          state_d = S_ERR;
      end
      S_T1L: begin
        Read    = 1'b1;
        MDRin   = 1'b1;
        state_d = S_T2;
      end
      S_T2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        Grb   = 1'b1;
        BAout = 1'b1;
        Rout  = 1'b1;
        Yin   = 1'b1;
        if (op_ld || op_ldi || op_st)
          state_d = S_T4;
        else
          state_d = S_ERR;
      end
      S_T4: begin
        Cout    = 1'b1;
        ZlowIn  = 1'b1;
        alu_op  = ADD_OP;
        state_d = op_ldi ? S_T5I : S_T5;
      end
      S_T5I: begin
        Zlowout = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
        state_d = S_DONE;
      end
      S_T5: begin
        Zlowout = 1'b1;
        MARin   = 1'b1;
        state_d = op_st ? S_T6S : S_T6;
      end
      S_T6: begin
        Read = 1'b1;
        if (mem_ready)
          state_d = S_T6L;
        else if (timed_out)
          state_d = S_ERR;
      end
      S_T6L: begin
        Read    = 1'b1;
        MDRin   = 1'b1;
        state_d = S_T7;
      end
      S_T7: begin
        MDRout  = 1'b1;
        Gra     = 1'b1;
        Rin     = 1'b1;
        state_d = S_DONE;
      end
      S_T6S: begin
        Gra         = 1'b1;
        Rout        = 1'b1;
        MDRin       = 1'b1;
        mdr_bus_sel = 1'b1;
        state_d     = S_T7S;
      end
      S_T7S: begin
        Write = 1'b1;
        if (mem_ready)
          state_d = S_DONE;
        else if (timed_out)
          state_d = S_ERR;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_ERR: begin
        error   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign step = state_q;

endmodule
